// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a single-port RAM.
// Serialises word reads and writes and returns read data to the issuing requester.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,

    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;       // 0 favours req0 on a tie
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [1:0]        cnt_q, cnt_d;

    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              ram_wr_en_q, ram_wr_en_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wr_data_q, ram_wr_data_d;

    logic              pick;

    // Outputs are registered so they change on the transition into the state
    // they belong to; ram_addr/ram_wr_data double as the latched command.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        win_d         = win_q;
        we_d          = we_q;
        cnt_d         = cnt_q;
        gnt0_d        = 1'b0;
        gnt1_d        = 1'b0;
        rvalid0_d     = 1'b0;
        rvalid1_d     = 1'b0;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        ram_wr_en_d   = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_wr_data_d = ram_wr_data_q;
        pick          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    // Lone requester always wins; the pointer only breaks ties.
                    pick          = (req0 && req1) ? ptr_q : req1;
                    win_d         = pick;
                    we_d          = pick ? we1 : we0;
                    ram_addr_d    = pick ? addr1 : addr0;
                    ram_wr_data_d = pick ? wdata1 : wdata0;
                    ram_wr_en_d   = pick ? we1 : we0;
                    gnt0_d        = ~pick;
                    gnt1_d        = pick;
                    state_d       = StIssue;
                end
            end

            StIssue: begin
                ptr_d = ~win_q;
                if (we_q) begin
                    state_d = StIdle;
                end else begin
                    cnt_d   = 2'(RD_LAT - 1);
                    state_d = StWait;
                end
            end

            StWait: begin
                if (cnt_q == 2'd0) begin
                    if (win_q) begin
                        rdata1_d  = ram_rd_data;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = ram_rd_data;
                        rvalid0_d = 1'b1;
                    end
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            ptr_q         <= 1'b0;
            win_q         <= 1'b0;
            we_q          <= 1'b0;
            cnt_q         <= 2'd0;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            ram_wr_en_q   <= 1'b0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            win_q         <= win_d;
            we_q          <= we_d;
            cnt_q         <= cnt_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            rvalid0_q     <= rvalid0_d;
            rvalid1_q     <= rvalid1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
        end
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign rvalid0     = rvalid0_q;
    assign rvalid1     = rvalid1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign ram_wr_en   = ram_wr_en_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wr_data = ram_wr_data_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 32x4 synchronous RAM.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ram_port_arbiter;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned RD_LAT = 1;

    logic              clk;
    logic              reset_n;
    logic              req0, we0, req1, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic [DATA_W-1:0] ram_rd_data;

    logic [DATA_W-1:0] mem [32];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];

    int n_cmp;
    int n_bad;

    logic [4:0] ctl;
    assign ctl = {gnt0, gnt1, rvalid0, rvalid1, ram_wr_en};

    ram_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req0        (req0),
        .we0         (we0),
        .addr0       (addr0),
        .wdata0      (wdata0),
        .gnt0        (gnt0),
        .rvalid0     (rvalid0),
        .rdata0      (rdata0),
        .req1        (req1),
        .we1         (we1),
        .addr1       (addr1),
        .wdata1      (wdata1),
        .gnt1        (gnt1),
        .rvalid1     (rvalid1),
        .rdata1      (rdata1),
        .ram_wr_en   (ram_wr_en),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
        rd_pipe[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rd_data = rd_pipe[RD_LAT-1];

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({ctl, ram_addr, ram_wr_data, rdata0, rdata1} !== 22'h0) begin
            n_bad++;
            $display("FAIL reset_init: got %h want 0",
                     {ctl, ram_addr, ram_wr_data, rdata0, rdata1});
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'h1F; wdata0 = 4'hF;
        @(negedge clk);
        n_cmp++;
        if (ctl !== 5'b10001) begin
            n_bad++;
            $display("FAIL reset_pre_issue: got %b want %b", ctl, 5'b10001);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({ctl, ram_addr, ram_wr_data, rdata0, rdata1} !== 22'h0) begin
            n_bad++;
            $display("FAIL reset_midrun: got %h want 0",
                     {ctl, ram_addr, ram_wr_data, rdata0, rdata1});
        end
        req0 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ctl !== 5'b00000) begin
                n_bad++;
                $display("FAIL reset_idle_%0d: got %b want %b", k, ctl, 5'b00000);
            end
        end
        n_cmp++;
        if (mem[31] !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_aborted_write: got %h want %h", mem[31], 4'h0);
        end
    endtask

    task automatic test_write();
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'h01; wdata0 = 4'h2;
        @(negedge clk);
        n_cmp++;
        if ({ctl, ram_addr, ram_wr_data} !== {5'b10001, 5'h01, 4'h2}) begin
            n_bad++;
            $display("FAIL write_issue: got %h want %h",
                     {ctl, ram_addr, ram_wr_data}, {5'b10001, 5'h01, 4'h2});
        end
        req0 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ctl, mem[1]} !== {5'b00000, 4'h2}) begin
            n_bad++;
            $display("FAIL write_done: got %h want %h", {ctl, mem[1]}, {5'b00000, 4'h2});
        end
    endtask

    task automatic test_read();
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'h01; wdata1 = 4'h0;
        @(negedge clk);
        n_cmp++;
        if ({ctl, ram_addr} !== {5'b01000, 5'h01}) begin
            n_bad++;
            $display("FAIL read_issue: got %h want %h", {ctl, ram_addr}, {5'b01000, 5'h01});
        end
        req1 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ctl, ram_addr} !== {5'b00000, 5'h01}) begin
            n_bad++;
            $display("FAIL read_wait: got %h want %h", {ctl, ram_addr}, {5'b00000, 5'h01});
        end
        @(negedge clk);
        n_cmp++;
        if ({ctl, rdata1} !== {5'b00010, 4'h2}) begin
            n_bad++;
            $display("FAIL read_rvalid: got %h want %h", {ctl, rdata1}, {5'b00010, 4'h2});
        end
        @(negedge clk);
        n_cmp++;
        if ({ctl, rdata1} !== {5'b00000, 4'h2}) begin
            n_bad++;
            $display("FAIL read_hold: got %h want %h", {ctl, rdata1}, {5'b00000, 4'h2});
        end
    endtask

    task automatic test_both_writes();
        logic [4:0] exp_ctl  [8];
        logic [4:0] exp_addr [8];
        logic [3:0] exp_data [8];
        exp_ctl  = '{5'b10001, 5'b0, 5'b01001, 5'b0, 5'b10001, 5'b0, 5'b01001, 5'b0};
        exp_addr = '{5'h0A, 5'h0, 5'h0B, 5'h0, 5'h0C, 5'h0, 5'h0D, 5'h0};
        exp_data = '{4'h5, 4'h0, 4'h6, 4'h0, 4'h7, 4'h0, 4'h8, 4'h0};
        reset_n = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'h0A; wdata0 = 4'h5;
        req1 = 1'b1; we1 = 1'b1; addr1 = 5'h0B; wdata1 = 4'h6;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ctl !== exp_ctl[k]) begin
                n_bad++;
                $display("FAIL both_ctl_%0d: got %b want %b", k, ctl, exp_ctl[k]);
            end
            if (exp_ctl[k] != 5'b0) begin
                n_cmp++;
                if ({ram_addr, ram_wr_data} !== {exp_addr[k], exp_data[k]}) begin
                    n_bad++;
                    $display("FAIL both_cmd_%0d: got %h want %h", k,
                             {ram_addr, ram_wr_data}, {exp_addr[k], exp_data[k]});
                end
            end
            if (k == 0) begin addr0 = 5'h0C; wdata0 = 4'h7; end
            if (k == 2) begin addr1 = 5'h0D; wdata1 = 4'h8; end
            if (k == 4) req0 = 1'b0;
            if (k == 6) req1 = 1'b0;
        end
        n_cmp++;
        if ({mem[10], mem[11], mem[12], mem[13]} !== 16'h5678) begin
            n_bad++;
            $display("FAIL both_mem: got %h want %h",
                     {mem[10], mem[11], mem[12], mem[13]}, 16'h5678);
        end
    endtask

    task automatic test_tie_after_gnt0();
        // Pointer favours req0 here; a lone req1 must still win.
        req1 = 1'b1; we1 = 1'b1; addr1 = 5'h11; wdata1 = 4'h3;
        @(negedge clk);
        n_cmp++;
        if ({ctl, ram_addr} !== {5'b01001, 5'h11}) begin
            n_bad++;
            $display("FAIL lone_req1: got %h want %h", {ctl, ram_addr}, {5'b01001, 5'h11});
        end
        req1 = 1'b0;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'h12; wdata0 = 4'h4;
        @(negedge clk);
        n_cmp++;
        if ({ctl, ram_addr} !== {5'b10001, 5'h12}) begin
            n_bad++;
            $display("FAIL lone_req0: got %h want %h", {ctl, ram_addr}, {5'b10001, 5'h12});
        end
        req0 = 1'b0;
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'h13; wdata0 = 4'hA;
        req1 = 1'b1; we1 = 1'b1; addr1 = 5'h14; wdata1 = 4'hB;
        @(negedge clk);
        n_cmp++;
        if ({ctl, ram_addr, ram_wr_data} !== {5'b01001, 5'h14, 4'hB}) begin
            n_bad++;
            $display("FAIL tie_first: got %h want %h",
                     {ctl, ram_addr, ram_wr_data}, {5'b01001, 5'h14, 4'hB});
        end
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({ctl, ram_addr, ram_wr_data} !== {5'b10001, 5'h13, 4'hA}) begin
            n_bad++;
            $display("FAIL tie_second: got %h want %h",
                     {ctl, ram_addr, ram_wr_data}, {5'b10001, 5'h13, 4'hA});
        end
        req0 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem[17], mem[18], mem[19], mem[20]} !== 16'h34AB) begin
            n_bad++;
            $display("FAIL tie_mem: got %h want %h",
                     {mem[17], mem[18], mem[19], mem[20]}, 16'h34AB);
        end
    endtask

    task automatic test_reset_in_wait();
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h0A; wdata0 = 4'h0;
        @(negedge clk);
        n_cmp++;
        if ({ctl, ram_addr} !== {5'b10000, 5'h0A}) begin
            n_bad++;
            $display("FAIL rw_issue: got %h want %h", {ctl, ram_addr}, {5'b10000, 5'h0A});
        end
        req0 = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({ctl, ram_addr, rdata0} !== 14'h0) begin
            n_bad++;
            $display("FAIL rw_reset_now: got %h want 0", {ctl, ram_addr, rdata0});
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({ctl, rdata0} !== 9'h0) begin
                n_bad++;
                $display("FAIL rw_no_rvalid_%0d: got %h want 0", k, {ctl, rdata0});
            end
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h0C;
        @(negedge clk);
        n_cmp++;
        if ({ctl, ram_addr} !== {5'b10000, 5'h0C}) begin
            n_bad++;
            $display("FAIL rw_reissue: got %h want %h", {ctl, ram_addr}, {5'b10000, 5'h0C});
        end
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({ctl, rdata0} !== {5'b00100, 4'h7}) begin
            n_bad++;
            $display("FAIL rw_rvalid0: got %h want %h", {ctl, rdata0}, {5'b00100, 4'h7});
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
        reset_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

        test_reset();
        test_write();
        test_read();
        test_both_writes();
        test_tie_after_gnt0();
        test_reset_in_wait();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
